// File: rtl/envelope_sequencer.sv
// Multi-voice 4-bit envelope stepper sharing one synchronous instrument ROM port.
// Optional loop points / note-off release enabled by defining ENVELOPE_SEQUENCER_LOOP_EN.
module envelope_sequencer #(
   parameter logic [7:0] BASE_ADDRESS = 8'h00,
   parameter int         NUM_CHANNELS = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_strobe,
   input  logic [NUM_CHANNELS-1:0]   i_load,
   input  logic [4*NUM_CHANNELS-1:0] i_instrument,
   input  logic [NUM_CHANNELS-1:0]   i_release,
   output logic                      o_busy,
   output logic                      o_valid,
   output logic [4*NUM_CHANNELS-1:0] o_amplitude,
   output logic [7:0]                o_rom_addr,
   input  logic [15:0]               i_rom_data
);

   localparam int            CW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int            SLOTS   = 1 << CW;
   localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEN_ADDR,
      LEN_READ,
      LOOP_ADDR,
      LOOP_READ,
      ENV_ADDR,
      ENV_READ,
      DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   ch;
   logic [CW-1:0]   ch_next;
   logic [SLOTS-1:0] load_q;
   logic [3:0]      inst_r [SLOTS];
   logic [3:0]      len_r  [SLOTS];
   logic [3:0]      idx_r  [SLOTS];
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
   logic [3:0]      loop_r [SLOTS];
   logic [SLOTS-1:0] released_r;
`else
   logic            unused_release;
   assign unused_release = ^i_release;
`endif

   logic [3:0] cur_inst;
   logic [3:0] cur_len;
   logic [3:0] cur_idx;
   logic [3:0] next_idx;

   assign cur_inst = inst_r[ch];
   assign cur_len  = len_r[ch];
   assign cur_idx  = idx_r[ch];
   assign ch_next  = ch + 1'b1;

   function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] k);
      return w[{k, 2'b00} +: 4];
   endfunction

   // Step advance: walk to the last step, then jump to the loop point unless released.
   always_comb begin
      next_idx = cur_idx;
      if (cur_idx < cur_len) begin
         next_idx = cur_idx + 4'd1;
      end
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
      else if (loop_r[ch] != 4'hF && loop_r[ch] <= cur_len && !released_r[ch]) begin
         next_idx = loop_r[ch];
      end
`endif
   end

   always_comb begin
      o_rom_addr = 8'h00;
      case (state)
         LEN_ADDR:  o_rom_addr = BASE_ADDRESS + {6'b0, cur_inst[3:2]};
         LOOP_ADDR: o_rom_addr = BASE_ADDRESS + 8'd4 + {6'b0, cur_inst[3:2]};
         ENV_ADDR:  o_rom_addr = BASE_ADDRESS + 8'd8 + {2'b00, cur_inst, 2'b00} + {6'b0, cur_idx[3:2]};
         default:   o_rom_addr = 8'h00;
      endcase
   end

   // Note-on/off are applied to the channel registers at strobe time so the
   // pass itself only has to fetch table data for the current channel.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         ch          <= '0;
         load_q      <= '0;
         o_busy      <= 1'b0;
         o_valid     <= 1'b0;
         o_amplitude <= '0;
         for (int c = 0; c < SLOTS; c++) begin
            inst_r[c] <= '0;
            len_r[c]  <= '0;
            idx_r[c]  <= '0;
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
            loop_r[c] <= '0;
`endif
         end
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
         released_r <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_strobe) begin
                  o_busy <= 1'b1;
                  load_q <= SLOTS'(i_load);
                  ch     <= '0;
                  for (int c = 0; c < NUM_CHANNELS; c++) begin
                     if (i_load[c]) begin
                        inst_r[c] <= i_instrument[4*c +: 4];
                        idx_r[c]  <= 4'd0;
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
                        released_r[c] <= 1'b0;
                     end else if (i_release[c]) begin
                        released_r[c] <= 1'b1;
`endif
                     end
                  end
                  state <= i_load[0] ? LEN_ADDR : ENV_ADDR;
               end
            end
            LEN_ADDR: state <= LEN_READ;
            LEN_READ: begin
               len_r[ch] <= nib(i_rom_data, cur_inst[1:0]);
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
               state <= LOOP_ADDR;
`else
               state <= ENV_ADDR;
`endif
            end
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
            LOOP_ADDR: state <= LOOP_READ;
            LOOP_READ: begin
               loop_r[ch] <= nib(i_rom_data, cur_inst[1:0]);
               state      <= ENV_ADDR;
            end
`endif
            ENV_ADDR: state <= ENV_READ;
            ENV_READ: begin
               o_amplitude[{ch, 2'b00} +: 4] <= nib(i_rom_data, cur_idx[1:0]);
               idx_r[ch] <= next_idx;
               if (ch == LAST_CH) begin
                  o_valid <= 1'b1;
                  state   <= DONE;
               end else begin
                  ch    <= ch_next;
                  state <= load_q[ch_next] ? LEN_ADDR : ENV_ADDR;
               end
            end
            DONE: begin
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
